// File: rtl/exc_ctrl.sv
// Exception control stage: captures ROB-head exceptions, flushes, and redirects fetch to the IVT handler or back from eret.
// Optional per-cause saturating exception counters are enabled with `define EXC_STATS_EN.
module exc_ctrl #(
    parameter int unsigned PC_W         = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned RET_OFFSET   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            commit_valid,
    input  logic            commit_exc,
    input  logic [1:0]      commit_cause,
    input  logic [PC_W-1:0] commit_pc,
    input  logic            eret,
    input  logic [15:0]     handler_address,
    output logic [1:0]      rob_cause,
    output logic            flush,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic [PC_W-1:0] epc,
    output logic            in_handler,
    output logic            double_fault
`ifdef EXC_STATS_EN
    ,
    output logic [31:0]     exc_count
`endif
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_REDIRECT,
        S_HANDLER
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ret_q, ret_d;
    logic [PC_W-1:0]   epc_q, epc_d;
    logic [1:0]        cause_q, cause_d;
    logic              df_q, df_d;
    logic              flush_q, flush_d;
    logic              rv_q, rv_d;
    logic [PC_W-1:0]   rpc_q, rpc_d;
    logic              inh_q, inh_d;

    // Next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ret_d   = ret_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        df_d    = df_q;

        case (state_q)
            S_IDLE: begin
                if (commit_valid && commit_exc) begin
                    state_d = S_FLUSH;
                    cnt_d   = '0;
                    ret_d   = 1'b0;
                    epc_d   = commit_pc;
                    cause_d = commit_cause;
                end
            end
            S_FLUSH: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_REDIRECT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_REDIRECT: begin
                state_d = ret_q ? S_IDLE : S_HANDLER;
            end
            S_HANDLER: begin
                if (commit_valid) begin
                    if (commit_exc) df_d = 1'b1;
                    if (eret) begin
                        state_d = S_FLUSH;
                        cnt_d   = '0;
                        ret_d   = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        flush_d = (state_d == S_FLUSH);
        rv_d    = (state_d == S_REDIRECT);
        rpc_d   = '0;
        if (state_d == S_REDIRECT) begin
            rpc_d = ret_q ? (epc_q + PC_W'(RET_OFFSET)) : PC_W'(handler_address);
        end

        // in_handler only changes once a redirect has actually completed
        inh_d = inh_q;
        if (state_d == S_HANDLER) inh_d = 1'b1;
        else if (state_d == S_IDLE) inh_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ret_q   <= 1'b0;
            epc_q   <= '0;
            cause_q <= '0;
            df_q    <= 1'b0;
            flush_q <= 1'b0;
            rv_q    <= 1'b0;
            rpc_q   <= '0;
            inh_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            df_q    <= df_d;
            flush_q <= flush_d;
            rv_q    <= rv_d;
            rpc_q   <= rpc_d;
            inh_q   <= inh_d;
        end
    end

`ifdef EXC_STATS_EN
    logic [3:0][7:0] stat_q, stat_d;

    // Per-cause saturating count of accepted exceptions
    always_comb begin
        stat_d = stat_q;
        if (state_q == S_IDLE && commit_valid && commit_exc &&
            stat_q[commit_cause] != 8'hFF) begin
            stat_d[commit_cause] = stat_q[commit_cause] + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stat_q <= '0;
        else        stat_q <= stat_d;
    end

    assign exc_count = stat_q;
`endif

    assign rob_cause      = cause_q;
    assign flush          = flush_q;
    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;
    assign epc            = epc_q;
    assign in_handler     = inh_q;
    assign double_fault   = df_q;

endmodule
